// File: rtl/shift_flux_scheduler.sv
// shift_flux_scheduler: round-robin burst scheduler sharing one shift datapath among FLUX streams
module shift_flux_scheduler #(
   parameter int FLUX      = 2,
   parameter int BURST     = 4,
   parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
   parameter int CNT_WIDTH = (BURST > 1) ? $clog2(BURST) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [FLUX-1:0]      empty,
   input  logic [FLUX-1:0]      full,
   output logic [TAG_WIDTH-1:0] tag,
   output logic                 tag_valid,
   output logic [FLUX-1:0]      read,
   output logic [FLUX-1:0]      write,
   output logic                 fire
);
   typedef enum logic {IDLE, SERVE} state_e;

   state_e               st_q, st_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d, ptr_q, ptr_d, tag_nxt;
   logic [CNT_WIDTH-1:0] burst_q, burst_d;
   logic [FLUX-1:0]      eligible;
   logic                 pick_ptr_ok, pick_rel_ok;
   logic [TAG_WIDTH-1:0] pick_ptr, pick_rel;

   // first eligible index scanning p, p+1, ... with wrap; msb flags a valid pick
   function automatic logic [TAG_WIDTH:0] rr_pick(input logic [FLUX-1:0] el, input logic [TAG_WIDTH-1:0] p);
      logic [TAG_WIDTH:0] r;
      int j;
      r = '0;
      for (int k = FLUX - 1; k >= 0; k--) begin
         j = int'(p) + k;
         if (j >= FLUX) j = j - FLUX;
         if (el[j]) r = {1'b1, TAG_WIDTH'(j)};
      end
      return r;
   endfunction

   assign eligible                = ~empty & ~full;
   assign tag_nxt                 = (tag_q == TAG_WIDTH'(FLUX - 1)) ? '0 : tag_q + TAG_WIDTH'(1);
   assign {pick_ptr_ok, pick_ptr} = rr_pick(eligible, ptr_q);
   assign {pick_rel_ok, pick_rel} = rr_pick(eligible, tag_nxt);
   assign tag                     = tag_q;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         tag_q   <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
      end else begin
         st_q    <= st_d;
         tag_q   <= tag_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
      end
   end

   // next state: grant from IDLE, then hold, rotate on burst end or stall, drop on disable
   always_comb begin
      st_d    = st_q;
      tag_d   = tag_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      if (st_q == IDLE) begin
         if (en && pick_ptr_ok) begin
            st_d    = SERVE;
            tag_d   = pick_ptr;
            burst_d = '0;
         end
      end else if (!en) begin
         st_d  = IDLE;
         ptr_d = tag_nxt;
      end else if (fire && burst_q != CNT_WIDTH'(BURST - 1)) begin
         burst_d = burst_q + CNT_WIDTH'(1);
      end else begin
         ptr_d = tag_nxt;
         if (pick_rel_ok) begin
            tag_d   = pick_rel;
            burst_d = '0;
         end else begin
            st_d = IDLE;
         end
      end
   end

   // outputs: transfer only when the owner is still eligible this cycle
   always_comb begin
      tag_valid = (st_q == SERVE);
      fire      = tag_valid & en & eligible[tag_q];
      read      = fire ? (FLUX'(1) << tag_q) : '0;
      write     = read;
   end
endmodule

// File: tb/tb_shift_flux_scheduler.sv
// tb_shift_flux_scheduler: directed and random checks of the scheduler against a behavioural model
module tb_shift_flux_scheduler;
   localparam int FLUX  = 3;
   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [2:0] empty = 3'b111;
   logic [2:0] full = 3'b000;
   logic [1:0] tag;
   logic       tag_valid, fire;
   logic [2:0] rd, wr;

   int checks = 0;
   int errors = 0;
   int owner, served, start, last_tag;

   always #5 clk = ~clk;

   shift_flux_scheduler #(.FLUX(FLUX), .BURST(BURST)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .empty(empty), .full(full),
      .tag(tag), .tag_valid(tag_valid), .read(rd), .write(wr), .fire(fire)
   );

   function automatic int pick(input int p, input logic [2:0] el);
      int idx;
      for (int k = 0; k < FLUX; k++) begin
         idx = (p + k) % FLUX;
         if (el[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner    = -1;
      served   = 0;
      start    = 0;
      last_tag = 0;
   endtask

   task automatic release_grant(input logic [2:0] el);
      int p;
      start = (owner + 1) % FLUX;
      p     = pick(start, el);
      owner = p;
      if (p >= 0) begin
         served   = 0;
         last_tag = p;
      end
   endtask

   task automatic check_and_advance(input logic [2:0] e, input logic [2:0] f, input logic en_v);
      logic [2:0] el;
      int         fe, p;
      el = ~e & ~f;
      fe = 0;
      if (owner >= 0 && en_v && el[owner]) fe = 1;
      chk("tag_valid", tag_valid, (owner >= 0) ? 1 : 0);
      chk("tag", tag, last_tag);
      chk("fire", fire, fe);
      chk("read", rd, fe ? (1 << owner) : 0);
      chk("write", wr, fe ? (1 << owner) : 0);
      if (owner < 0) begin
         p = pick(start, el);
         if (en_v && p >= 0) begin
            owner    = p;
            served   = 0;
            last_tag = p;
         end
      end else if (!en_v) begin
         start = (owner + 1) % FLUX;
         owner = -1;
      end else if (fe == 1) begin
         served++;
         if (served == BURST) release_grant(el);
      end else begin
         release_grant(el);
      end
   endtask

   task automatic step(input logic [2:0] e, input logic [2:0] f, input logic en_v);
      empty = e;
      full  = f;
      en    = en_v;
      #1;
      check_and_advance(e, f, en_v);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_tag_valid", tag_valid, 0);
      chk("rst_tag", tag, 0);
      chk("rst_fire", fire, 0);
      chk("rst_read", rd, 0);
      chk("rst_write", wr, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [2:0] rand_mask(input int one_in);
      logic [2:0] m;
      for (int i = 0; i < 3; i++) m[i] = ($urandom_range(0, one_in - 1) == 0);
      return m;
   endfunction

   initial begin
      int dc;
      do_reset();
      repeat (10) step(3'b111, 3'b000, 1'b1);
      repeat (12) step(3'b101, 3'b000, 1'b1);
      repeat (16) step(3'b000, 3'b000, 1'b1);
      repeat (24) step(3'b000, (owner == 2 && served >= 2) ? 3'b100 : 3'b000, 1'b1);
      dc = 0;
      repeat (20) begin
         if (dc == 0 && owner == 0 && served == 1) dc = 1;
         if (dc > 0 && dc < 3) begin
            step(3'b000, 3'b000, 1'b0);
            dc++;
         end else begin
            step(3'b000, 3'b000, 1'b1);
         end
      end
      repeat (6) step(3'b000, 3'b000, 1'b1);
      do_reset();
      repeat (8) step(3'b000, 3'b000, 1'b1);
      repeat (600) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         else step(rand_mask(4), rand_mask(5), $urandom_range(0, 15) != 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
